// File: rtl/mem_port_requester.sv
// One-lane initiator for the shared-RAM arbiter: requests the lane, holds it
// for a full read/write burst, then releases and waits for the grant to drop.
module mem_port_requester #(
  parameter int SETTLE = 2,
  parameter int LEN_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [7:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  output logic             wr_pop,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             busy,
  output logic             mem_rden,
  output logic             mem_wren,
  output logic [7:0]       mem_addr,
  output logic [7:0]       mem_din,
  input  logic [7:0]       mem_dq,
  input  logic             mem_acq
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_BEAT    = 2'd2;
  localparam logic [1:0] S_RELEASE = 2'd3;

  localparam int              CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);

  logic [1:0]       r_state;
  logic             r_we;
  logic [LEN_W:0]   r_beats;
  logic [CNT_W-1:0] r_settle;
  logic [7:0]       r_addr;
  logic [7:0]       r_din;
  logic             r_din_pending;
  logic             r_rden;
  logic             r_wren;
  logic [7:0]       r_rd_data;
  logic             r_rd_valid;
  logic             r_wr_pop;
  logic             r_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_we          <= 1'b0;
      r_beats       <= '0;
      r_settle      <= '0;
      r_addr        <= 8'h00;
      r_din         <= 8'h00;
      r_din_pending <= 1'b0;
      r_rden        <= 1'b0;
      r_wren        <= 1'b0;
      r_rd_data     <= 8'h00;
      r_rd_valid    <= 1'b0;
      r_wr_pop      <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_rd_valid <= 1'b0;
      r_wr_pop   <= 1'b0;
      r_done     <= 1'b0;

      // The write source shows its next word one cycle after a pop.
      if (r_din_pending) begin
        r_din         <= wr_data;
        r_din_pending <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_we    <= cmd_we;
            r_beats <= {1'b0, cmd_len};
            r_addr  <= cmd_addr;
            if (cmd_we) r_din <= wr_data;
            r_rden  <= ~cmd_we;
            r_wren  <= cmd_we;
            r_state <= S_REQ;
          end
        end

        S_REQ: begin
          if (mem_acq) begin
            r_settle <= '0;
            r_state  <= S_BEAT;
          end
        end

        S_BEAT: begin
          if (!mem_acq) begin
            r_rden        <= 1'b0;
            r_wren        <= 1'b0;
            r_din_pending <= 1'b0;
            r_state       <= S_RELEASE;
          end else if (!r_din_pending) begin
            // Settle count stalls while the next write byte is being loaded.
            if (r_settle == SETTLE_LAST) begin
              if (r_we) begin
                r_wr_pop <= 1'b1;
              end else begin
                r_rd_data  <= mem_dq;
                r_rd_valid <= 1'b1;
              end
              if (r_beats != '0) begin
                r_addr        <= r_addr + 8'd1;
                r_beats       <= r_beats - (LEN_W+1)'(1);
                r_settle      <= '0;
                r_din_pending <= r_we;
              end else begin
                r_rden  <= 1'b0;
                r_wren  <= 1'b0;
                r_state <= S_RELEASE;
              end
            end else begin
              r_settle <= r_settle + CNT_W'(1);
            end
          end
        end

        S_RELEASE: begin
          if (!mem_acq) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign wr_pop    = r_wr_pop;
  assign rd_data   = r_rd_data;
  assign rd_valid  = r_rd_valid;
  assign done      = r_done;
  assign mem_rden  = r_rden;
  assign mem_wren  = r_wren;
  assign mem_addr  = r_addr;
  assign mem_din   = r_din;

endmodule

// File: tb/tb_mem_port_requester.sv
// Scoreboard bench: a behavioural arbiter lane and RAM drive the requester;
// expected beats are queued at command accept and checked by a monitor.
module tb_mem_port_requester;
  localparam int SETTLE = 2;
  localparam int LEN_W  = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic             cmd_we = 1'b0;
  logic [7:0]       cmd_addr = 8'h00;
  logic [LEN_W-1:0] cmd_len = '0;
  logic [7:0]       wr_data;
  logic             wr_pop;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             done;
  logic             busy;
  logic             mem_rden;
  logic             mem_wren;
  logic [7:0]       mem_addr;
  logic [7:0]       mem_din;
  logic [7:0]       mem_dq;
  logic             mem_acq = 1'b0;

  always #5 clk = ~clk;

  mem_port_requester #(.SETTLE(SETTLE), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_pop(wr_pop),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .busy(busy),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dq(mem_dq), .mem_acq(mem_acq)
  );

  typedef struct {
    bit       is_wr;
    logic [7:0] addr;
    logic [7:0] data;
  } exp_t;

  logic [7:0] ram     [256];
  logic [7:0] ref_mem [256];
  logic [7:0] wsrc    [4096];
  int         wrd_idx = 0;
  int         wis = 0;
  exp_t       exp_q[$];

  int checks = 0;
  int errors = 0;
  int gdelay = 1;
  int rdelay = 1;
  int abort_at = 0;
  bit allow_drop = 1'b0;
  int done_seen = 0;
  int exp_done = 0;

  assign wr_data = wsrc[wrd_idx];
  assign mem_dq  = ram[mem_addr];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Arbiter lane model: grant after gdelay, hold while requested, drop after rdelay.
  initial begin
    int cnt = 0;
    int gcyc = 0;
    forever begin
      @(negedge clk);
      if (wr_pop) wrd_idx++;
      if (!rst_n) begin
        mem_acq = 1'b0;
        cnt = 0;
      end else if (!mem_acq) begin
        if (mem_rden || mem_wren) begin
          if (cnt >= gdelay) begin
            mem_acq = 1'b1;
            cnt = 0;
            gcyc = 0;
          end else cnt++;
        end else cnt = 0;
      end else begin
        if (mem_wren) ram[mem_addr] = mem_din;
        gcyc++;
        if (abort_at != 0 && gcyc >= abort_at) begin
          mem_acq = 1'b0;
          cnt = 0;
          abort_at = 0;
        end else if (!(mem_rden || mem_wren)) begin
          if (cnt >= rdelay) begin
            mem_acq = 1'b0;
            cnt = 0;
          end else cnt++;
        end else cnt = 0;
      end
    end
  end

  // Monitor: beats, request continuity, stale-grant and done counting.
  initial begin
    logic       prev_req = 1'b0;
    logic       prev_rden = 1'b0;
    logic       prev_wren = 1'b0;
    logic [7:0] prev_addr = 8'h00;
    logic [7:0] prev_din = 8'h00;
    exp_t       e;
    forever begin
      @(posedge clk);
      #1;
      if (rd_valid || wr_pop) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {30'd0, rd_valid, wr_pop}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("beat_kind", wr_pop, e.is_wr);
          chk("beat_addr", prev_addr, e.addr);
          if (e.is_wr) chk("wr_din", prev_din, e.data);
          else         chk("rd_data", rd_data, e.data);
          $display("beat %s addr=%02h data=%02h", e.is_wr ? "WR" : "RD", e.addr, e.data);
        end
      end
      if (!allow_drop && prev_rden && !mem_rden) chk("rden_early_drop", exp_q.size(), 0);
      if (!allow_drop && prev_wren && !mem_wren) chk("wren_early_drop", exp_q.size(), 0);
      if (!prev_req && (mem_rden || mem_wren)) chk("stale_grant", mem_acq, 0);
      if (done) done_seen++;
      prev_req  = mem_rden | mem_wren;
      prev_rden = mem_rden;
      prev_wren = mem_wren;
      prev_addr = mem_addr;
      prev_din  = mem_din;
    end
  end

  task automatic issue(bit we, logic [7:0] a, int len);
    int n = 0;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_addr  = a;
    cmd_len   = LEN_W'(len);
    while (!cmd_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", busy, 0);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      e.is_wr = we;
      e.addr  = a + 8'(i);
      if (we) begin
        e.data = wsrc[wis + i];
        ref_mem[e.addr] = e.data;
      end else begin
        e.data = ref_mem[e.addr];
      end
      exp_q.push_back(e);
    end
    if (we) wis += len + 1;
    exp_done++;
    $display("cmd %s addr=%02h len=%0d", we ? "WR" : "RD", a, len);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || mem_acq) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy | mem_acq}, 32'd0);
  endtask

  initial begin
    int n;
    int mism;
    for (int i = 0; i < 256; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    for (int i = 0; i < 4096; i++) wsrc[i] = 8'($urandom);

    // Reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_req", {mem_rden, mem_wren}, 0);
    chk("rst_pulses", {rd_valid, wr_pop, done}, 0);
    chk("rst_addr_din", {mem_addr, mem_din}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read
    gdelay = 2;
    ram[8'h10] = 8'hA5;
    ref_mem[8'h10] = 8'hA5;
    issue(1'b0, 8'h10, 0);
    wait_idle();

    // Single write
    wsrc[wis] = 8'h3C;
    issue(1'b1, 8'h20, 0);
    wait_idle();
    chk("ram_20", ram[8'h20], 8'h3C);

    // Read burst with address wrap
    ram[8'hFE] = 8'h11; ram[8'hFF] = 8'h22; ram[8'h00] = 8'h33; ram[8'h01] = 8'h44;
    ref_mem[8'hFE] = 8'h11; ref_mem[8'hFF] = 8'h22; ref_mem[8'h00] = 8'h33; ref_mem[8'h01] = 8'h44;
    gdelay = 0;
    issue(1'b0, 8'hFE, 3);
    wait_idle();

    // Contention: grant withheld for about 10 cycles
    gdelay = 10;
    issue(1'b0, 8'h55, 1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("contend_req", {mem_rden, mem_acq, rd_valid, busy}, 4'b1001);
    end
    wait_idle();

    // Reset during beat 2 of 4
    gdelay = 1;
    issue(1'b0, 8'h40, 3);
    n = 0;
    while (exp_q.size() > 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("reset_reach_beat2", exp_q.size(), 3);
    @(negedge clk);
    allow_drop = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_outputs", {mem_rden, mem_wren, rd_valid, done}, 0);
    chk("arst_cmd_ready", cmd_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    exp_done--;
    wait_idle();
    allow_drop = 1'b0;
    issue(1'b0, 8'h40, 3);
    wait_idle();

    // Grant lost mid-burst: abort, done still pulses
    allow_drop = 1'b1;
    abort_at = 3;
    issue(1'b0, 8'h80, 5);
    wait_idle();
    chk("abort_done", done_seen, exp_done);
    chk("abort_cut_short", {31'd0, exp_q.size() > 0}, 32'd1);
    exp_q.delete();
    allow_drop = 1'b0;

    // Back-to-back: second command waits for full release
    gdelay = 1;
    rdelay = 3;
    issue(1'b1, 8'hC0, 1);
    issue(1'b0, 8'hC0, 1);
    wait_idle();

    // Randomized traffic
    for (int k = 0; k < 40; k++) begin
      int len;
      gdelay = $urandom_range(0, 4);
      rdelay = $urandom_range(0, 3);
      len = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      issue(1'($urandom_range(0, 1)), 8'($urandom), len);
      if ($urandom_range(0, 2) != 0) wait_idle();
    end
    wait_idle();
    repeat (3) @(negedge clk);

    chk("done_count", done_seen, exp_done);
    chk("queue_drained", exp_q.size(), 0);
    mism = 0;
    for (int i = 0; i < 256; i++) if (ram[i] !== ref_mem[i]) mism++;
    chk("ram_contents", mism, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
